// File: rtl/divider_if.sv
// Operand/result bundle for the iterative divider.
// The master drives the operands, and the slave (the divider) returns the result.
interface divider_if;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        validity;
    logic [31:0] result;

    modport master (
        output dividend,
        output divisor,
        input  validity,
        input  result
    );

    modport slave (
        input  dividend,
        input  divisor,
        output validity,
        output result
    );
endinterface

// File: rtl/divider.sv
// Unsigned 16/16 restoring divider, one quotient bit per clock, MSB first.
// result = {remainder, quotient}; it restarts on its own when the operands change.
module divider (
    input  logic      clk,
    input  logic      reset,
    divider_if.slave  bus
);

    typedef enum logic [1:0] {
        LOAD,
        BUSY,
        DONE
    } state_t;

    state_t      state_q;
    logic [15:0] dvd_q;
    logic [15:0] dvs_q;
    logic [15:0] work_q;
    logic [15:0] rem_q;
    logic [4:0]  cnt_q;
    logic [31:0] result_q;
    logic        validity_q;

    logic [16:0] shift_d;
    logic        fits_d;
    logic [15:0] rem_d;
    logic [15:0] work_d;
    logic        changed_d;

    // work_q starts as the dividend; each step moves its MSB into the remainder
    // and shifts the new quotient bit in at the LSB. After 16 steps it holds the quotient.
    always_comb begin
        shift_d   = {rem_q, work_q[15]};
        fits_d    = shift_d >= {1'b0, dvs_q};
        rem_d     = fits_d ? 16'(shift_d - {1'b0, dvs_q}) : shift_d[15:0];
        work_d    = {work_q[14:0], fits_d};
        changed_d = (bus.dividend != dvd_q) || (bus.divisor != dvs_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= LOAD;
            dvd_q      <= '0;
            dvs_q      <= '0;
            work_q     <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            result_q   <= '0;
            validity_q <= 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    dvd_q      <= bus.dividend;
                    dvs_q      <= bus.divisor;
                    work_q     <= bus.dividend;
                    rem_q      <= '0;
                    cnt_q      <= '0;
                    validity_q <= 1'b0;
                    state_q    <= BUSY;
                end
                BUSY: begin
                    rem_q  <= rem_d;
                    work_q <= work_d;
                    cnt_q  <= cnt_q + 5'd1;
                    if (cnt_q == 5'd15) begin
                        result_q   <= {rem_d, work_d};
                        validity_q <= 1'b1;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    if (changed_d) begin
                        validity_q <= 1'b0;
                        state_q    <= LOAD;
                    end
                end
                default: begin
                    validity_q <= 1'b0;
                    state_q    <= LOAD;
                end
            endcase
        end
    end

    assign bus.result   = result_q;
    assign bus.validity = validity_q;

endmodule

// File: tb/tb_divider.sv
// Directed and random checks of the divider against an arithmetic {a % b, a / b} model.
// Latency is counted as 17 rising edges, starting with the LOAD edge.
module tb_divider;

    logic clk;
    logic reset;
    int unsigned errors;
    int unsigned checks;
    logic [31:0] exp_q;

    divider_if bus ();

    divider dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_div(input logic [15:0] a, input logic [15:0] b);
        int unsigned ai;
        int unsigned bi;
        ai = a;
        bi = b;
        if (bi == 0)
            return {a, 16'hFFFF};
        return {16'(ai % bi), 16'(ai / bi)};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called 1 time unit after an edge while in DONE. It applies new operands
    // and checks the drop, the retained result, the exact latency and the final value.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] e;
        e = ref_div(a, b);
        bus.dividend = a;
        bus.divisor  = b;
        step(1);
        chk({tag, "_drop"}, 32'(bus.validity), 32'd0);
        chk({tag, "_hold"}, bus.result, exp_q);
        step(16);
        chk({tag, "_early"}, 32'(bus.validity), 32'd0);
        step(1);
        chk({tag, "_valid"}, 32'(bus.validity), 32'd1);
        chk({tag, "_result"}, bus.result, e);
        exp_q = e;
    endtask

    initial begin
        logic [15:0] a;
        logic [15:0] b;
        errors = 0;
        checks = 0;
        reset = 1'b1;
        bus.dividend = 16'd23;
        bus.divisor  = 16'd6;
        step(2);
        chk("rst_valid", 32'(bus.validity), 32'd0);
        chk("rst_result", bus.result, 32'h0000_0000);

        // First edge after release performs LOAD
        reset = 1'b0;
        step(16);
        chk("first_early", 32'(bus.validity), 32'd0);
        chk("first_hold", bus.result, 32'h0000_0000);
        step(1);
        chk("first_valid", 32'(bus.validity), 32'd1);
        chk("first_result", bus.result, 32'h0005_0003);
        step(5);
        chk("first_stable_v", 32'(bus.validity), 32'd1);
        chk("first_stable_r", bus.result, 32'h0005_0003);
        exp_q = 32'h0005_0003;

        run_op("ffff_1", 16'hFFFF, 16'd1);
        chk("ffff_1_const", bus.result, 32'h0000_FFFF);
        run_op("div0", 16'd100, 16'd0);
        chk("div0_const", bus.result, 32'h0064_FFFF);
        run_op("small", 16'd5, 16'd9);
        chk("small_const", bus.result, 32'h0005_0000);
        run_op("50_7", 16'd50, 16'd7);
        chk("50_7_const", bus.result, 32'h0001_0007);
        run_op("0_0", 16'd0, 16'd0);
        run_op("max_max", 16'hFFFF, 16'hFFFF);

        // Operand changes during BUSY must not disturb the running division
        bus.dividend = 16'd1000;
        bus.divisor  = 16'd7;
        step(1);
        chk("busy_chg_drop", 32'(bus.validity), 32'd0);
        step(6);
        bus.dividend = 16'd999;
        bus.divisor  = 16'd3;
        step(10);
        chk("busy_chg_early", 32'(bus.validity), 32'd0);
        step(1);
        chk("busy_chg_valid", 32'(bus.validity), 32'd1);
        chk("busy_chg_result", bus.result, ref_div(16'd1000, 16'd7));
        exp_q = ref_div(16'd1000, 16'd7);
        step(1);
        chk("busy_chg_restart", 32'(bus.validity), 32'd0);
        step(16);
        chk("busy_chg2_early", 32'(bus.validity), 32'd0);
        step(1);
        chk("busy_chg2_result", bus.result, ref_div(16'd999, 16'd3));

        // Reset during BUSY cycle 8 aborts the operation
        bus.dividend = 16'd23;
        bus.divisor  = 16'd6;
        step(2);
        step(8);
        reset = 1'b1;
        step(1);
        chk("abort_valid", 32'(bus.validity), 32'd0);
        chk("abort_result", bus.result, 32'h0000_0000);
        reset = 1'b0;
        step(16);
        chk("abort_early", 32'(bus.validity), 32'd0);
        step(1);
        chk("abort_valid2", 32'(bus.validity), 32'd1);
        chk("abort_result2", bus.result, 32'h0005_0003);
        exp_q = 32'h0005_0003;

        for (int i = 0; i < 1000; i++) begin
            a = 16'($urandom);
            b = (i % 2 == 0) ? 16'($urandom_range(1, 65535)) : 16'($urandom_range(1, 255));
            if (a == bus.dividend && b == bus.divisor)
                a = a + 16'd1;
            run_op("rand", a, b);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
